// File: rtl/gpio_input_port.sv
// Debounced GPIO input port with sticky edge capture, interrupt mask and register read-back.
// Define GPIO_INPUT_PORT_DEBOUNCE_EN to add the 1 ms, three-sample debounce filter.
module gpio_input_port #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 48000
) (
  input  logic             clk_48mhz,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_INPUT_PORT_DEBOUNCE_EN
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick;
  logic [WIDTH-1:0][2:0] hist_q, hist_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // State flips on the very edge the history becomes three equal samples.
  always_comb begin : debounce_comb
    logic [2:0] h;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    hist_d  = hist_q;
    state_d = state_q;
    h       = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        h         = {hist_q[i][1:0], sync2_q[i]};
        hist_d[i] = h;
        if (&h) begin
          state_d[i] = 1'b1;
        end else if (~|h) begin
          state_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      hist_q  <= '0;
      state_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      state_q <= state_d;
    end
  end
`else
  // Without the filter the second synchronizer stage is the state itself.
  assign state_q = sync2_q;
  assign state_d = sync1_q;
`endif

  // rd_en/wr_en are single-cycle strobes qualified by addr; a read captures the
  // pre-write value and rd_data holds it until the next rd_en.
  always_comb begin
    clr       = (wr_en && addr == ADDR_EDGE) ? wr_data : '0;
    rise      = state_d & ~state_q;
    fall      = ~state_d & state_q;
    edge_d    = (edge_q & ~clr) | (rise & sel_q) | (fall & ~sel_q);
    mask_d    = (wr_en && addr == ADDR_IRQ_MASK) ? wr_data : mask_q;
    sel_d     = (wr_en && addr == ADDR_EDGE_SEL) ? wr_data : sel_q;
    irq_d     = |(edge_q & mask_q);
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (addr)
        ADDR_DATA:     rd_data_d = state_q;
        ADDR_EDGE:     rd_data_d = edge_q;
        ADDR_IRQ_MASK: rd_data_d = mask_q;
        ADDR_EDGE_SEL: rd_data_d = sel_q;
        default:       rd_data_d = rd_data_q;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      edge_q    <= '0;
      mask_q    <= '0;
      sel_q     <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule
